capture14_ringbuf: RTL and testbench

- Trigger-driven snapshot buffer for 14-bit sample words (NSAMP samples per clock).
- Sits directly downstream of the distributed-RAM sample delay line. The delay re-aligns the data with trigger-decision latency, so pre-trigger samples land in the capture.
- Writes continuously into a circular RAM. On an accepted trigger it records POST_LEN further words, freezes, then streams the whole buffer out oldest-first over a valid/ready interface.
- Re-arms automatically after the last word has been transferred.

---
 rtl/capture14_ringbuf.sv | 95 +++++++++
 tb/tb_capture14_ringbuf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture14_ringbuf.sv
// capture14_ringbuf: trigger-driven snapshot buffer for 14-bit sample words.
// Circular capture RAM, freezes POST_LEN words after a trigger, oldest-first readout.
module capture14_ringbuf #(
    parameter int NSAMP      = 1,
    parameter int DEPTH_LOG2 = 5,
    parameter int POST_LEN   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [14*NSAMP-1:0] dat_i,
    input  logic                trig_i,
    output logic                armed_o,
    output logic                busy_o,
    output logic [14*NSAMP-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast
);
    localparam int W     = 14 * NSAMP;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int RW    = DEPTH_LOG2 + 1;

    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [RW-1:0] ONE_R     = RW'(1);
    localparam logic [AW-1:0] LAST_FILL = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_POST = AW'((POST_LEN == 0) ? 0 : POST_LEN - 1);
    localparam logic [RW-1:0] LAST_RD   = RW'(DEPTH - 1);
    localparam logic [RW-1:0] N_RD      = RW'(DEPTH);

    typedef enum logic [1:0] {FILL, ARMED, POST, READ} state_t;
    state_t state, state_nx;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] fillcnt;
    logic [AW-1:0] postcnt;
    logic [AW-1:0] raddr;
    logic [RW-1:0] rcnt;
    logic          wr;
    logic          load;
    logic          done;

    // wptr is frozen during READ, so it doubles as the oldest-word base
    assign wr      = (state != READ);
    assign raddr   = wptr + rcnt[AW-1:0];
    assign load    = (state == READ) && (rcnt != N_RD) && (!m_tvalid || m_tready);
    assign done    = m_tvalid && m_tready && m_tlast;
    assign armed_o = (state == ARMED);
    assign busy_o  = (state == POST) || (state == READ);

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:    if (fillcnt == LAST_FILL) state_nx = ARMED;
            ARMED:   if (trig_i) state_nx = (POST_LEN == 0) ? READ : POST;
            POST:    if (postcnt == LAST_POST) state_nx = READ;
            READ:    if (done) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem[wptr] <= dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= FILL;
            wptr     <= '0;
            fillcnt  <= '0;
            postcnt  <= '0;
            rcnt     <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            state   <= state_nx;
            if (wr) wptr <= wptr + ONE_A;
            fillcnt <= (state == FILL) ? fillcnt + ONE_A : '0;
            postcnt <= (state == POST) ? postcnt + ONE_A : '0;
            if (state != READ) rcnt <= '0;
            else if (load) rcnt <= rcnt + ONE_R;
            // output register only advances when empty or being drained
            if (load) begin
                m_tdata  <= mem[raddr];
                m_tvalid <= 1'b1;
                m_tlast  <= (rcnt == LAST_RD);
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture14_ringbuf.sv
// tb_capture14_ringbuf: directed checks of capture14_ringbuf in three configs.
// Counter-valued samples make every readout word predictable by hand.
module tb_capture14_ringbuf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic        rst_a, trig_a, rdy_a, armed_a, busy_a, tv_a, tl_a;
    logic [13:0] dat_a, td_a;
    logic        rst_b, trig_b, rdy_b, armed_b, busy_b, tv_b, tl_b;
    logic [13:0] dat_b, td_b;
    logic        rst_c, trig_c, rdy_c, armed_c, busy_c, tv_c, tl_c;
    logic [55:0] dat_c, td_c;

    capture14_ringbuf #(.NSAMP(1), .DEPTH_LOG2(4), .POST_LEN(5)) u_a (
        .clk_i(clk), .rst_i(rst_a), .dat_i(dat_a), .trig_i(trig_a),
        .armed_o(armed_a), .busy_o(busy_a), .m_tdata(td_a),
        .m_tvalid(tv_a), .m_tready(rdy_a), .m_tlast(tl_a)
    );

    capture14_ringbuf #(.NSAMP(1), .DEPTH_LOG2(4), .POST_LEN(0)) u_b (
        .clk_i(clk), .rst_i(rst_b), .dat_i(dat_b), .trig_i(trig_b),
        .armed_o(armed_b), .busy_o(busy_b), .m_tdata(td_b),
        .m_tvalid(tv_b), .m_tready(rdy_b), .m_tlast(tl_b)
    );

    capture14_ringbuf #(.NSAMP(4), .DEPTH_LOG2(4), .POST_LEN(3)) u_c (
        .clk_i(clk), .rst_i(rst_c), .dat_i(dat_c), .trig_i(trig_c),
        .armed_o(armed_c), .busy_o(busy_c), .m_tdata(td_c),
        .m_tvalid(tv_c), .m_tready(rdy_c), .m_tlast(tl_c)
    );

    typedef struct {
        string name;
        int    trig_at;
        int    first;
        int    tidx;
        bit    rnd;
    } cap_t;

    cap_t tab[2];

    logic [14:0] qa[$];
    logic [14:0] qb[$];
    logic [56:0] qc[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] lanes(input int v);
        logic [55:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[14*k +: 14] = 14'(4 * v + k);
        return r;
    endfunction

    // one clock: log transfers seen at this edge, then advance the sample counter
    task automatic cyc();
        logic        stall;
        logic [14:0] held;
        stall = tv_a && !rdy_a && !rst_a;
        held  = {tl_a, td_a};
        if (tv_a && rdy_a) qa.push_back({tl_a, td_a});
        if (tv_b && rdy_b) qb.push_back({tl_b, td_b});
        if (tv_c && rdy_c) qc.push_back({tl_c, td_c});
        @(posedge clk);
        #1;
        if (stall) begin
            chk("stall_valid", tv_a, 1);
            chk("stall_hold", {tl_a, td_a}, held);
        end
        n++;
        dat_a = 14'(n);
        dat_b = 14'(n);
        dat_c = lanes(n);
    endtask

    task automatic capture_a(input cap_t c, input int stop_at);
        int k;
        k = 0;
        while (!armed_a && k < 200) begin cyc(); k++; end
        chk({c.name, "_armed"}, armed_a, 1);
        k = 0;
        while (n != c.trig_at && k < 1000) begin cyc(); k++; end
        qa.delete();
        trig_a = 1'b1;
        cyc();
        chk({c.name, "_busy"}, busy_a, 1);
        chk({c.name, "_disarm"}, armed_a, 0);
        repeat (5) cyc();
        trig_a = 1'b0;
        chk({c.name, "_vld_f1"}, tv_a, 0);
        cyc();
        chk({c.name, "_vld_f2"}, tv_a, 1);
        k = 0;
        while (qa.size() < stop_at && k < 300) begin
            if (c.rnd) rdy_a = 1'($urandom_range(0, 1));
            cyc();
            k++;
        end
        rdy_a = 1'b1;
        chk({c.name, "_count"}, qa.size(), stop_at);
        if (stop_at == 16) begin
            chk({c.name, "_vld_end"}, tv_a, 0);
            chk({c.name, "_idle"}, busy_a, 0);
            for (int i = 0; i < 16 && i < qa.size(); i++) begin
                chk({c.name, "_data"}, qa[i][13:0], 14'(c.first + i));
                chk({c.name, "_last"}, qa[i][14], (i == 15));
            end
            if (qa.size() > c.tidx)
                chk({c.name, "_trigword"}, qa[c.tidx][13:0], 14'(c.trig_at));
        end
    endtask

    initial begin
        int  k;
        bit  seen;
        bit  anylast;
        tab[0] = '{"basic", 100, 90, 10, 1'b0};
        tab[1] = '{"rnd_rdy", 300, 290, 10, 1'b1};

        rst_a = 1; rst_b = 1; rst_c = 1;
        trig_a = 0; trig_b = 0; trig_c = 0;
        rdy_a = 1; rdy_b = 1; rdy_c = 1;
        dat_a = '0; dat_b = '0; dat_c = '0;
        repeat (3) cyc();
        chk("rst_armed", armed_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_tvalid", tv_a, 0);
        chk("rst_tlast", tl_a, 0);
        chk("rst_tdata", td_a, 0);

        // fill with trigger held high: must be ignored, arm after 16 writes
        n = 0; dat_a = '0;
        rst_a = 0;
        trig_a = 1;
        k = 0;
        while (!armed_a && k < 40) begin
            cyc();
            k++;
        end
        trig_a = 0;
        chk("fill_arm_cycles", k, 16);
        chk("fill_trig_ign", busy_a, 0);

        for (int t = 0; t < 2; t++) begin
            capture_a(tab[t], 16);
            trig_a = 1;
            seen = 0;
            k = 0;
            while (!armed_a && k < 40) begin
                cyc();
                k++;
                if (tv_a) seen = 1;
            end
            trig_a = 0;
            chk({tab[t].name, "_rearm"}, k, 16);
            chk({tab[t].name, "_single"}, seen, 0);
        end

        // abort readout with reset after five transfers
        capture_a('{"abort", 500, 490, 10, 1'b0}, 5);
        rst_a = 1;
        cyc();
        chk("abort_tvalid", tv_a, 0);
        chk("abort_tlast", tl_a, 0);
        chk("abort_busy", busy_a, 0);
        anylast = 0;
        foreach (qa[i]) anylast |= qa[i][14];
        chk("abort_nolast", anylast, 0);
        rst_a = 0;
        k = 0;
        while (!armed_a && k < 40) begin cyc(); k++; end
        chk("abort_rearm", k, 16);
        capture_a('{"post_rst", 700, 690, 10, 1'b0}, 16);

        // POST_LEN = 0: trigger word is the newest one
        n = 0; dat_b = '0;
        rst_b = 0;
        k = 0;
        while (n != 50 && k < 100) begin cyc(); k++; end
        chk("b_armed", armed_b, 1);
        qb.delete();
        trig_b = 1;
        cyc();
        trig_b = 0;
        chk("b_busy", busy_b, 1);
        chk("b_vld_f1", tv_b, 0);
        cyc();
        chk("b_vld_f2", tv_b, 1);
        k = 0;
        while (qb.size() < 16 && k < 100) begin cyc(); k++; end
        chk("b_count", qb.size(), 16);
        for (int i = 0; i < qb.size(); i++) begin
            chk("b_data", qb[i][13:0], 14'(35 + i));
            chk("b_last", qb[i][14], (i == 15));
        end

        // four lanes, trigger held high: back-to-back captures every 37 cycles
        n = 0; dat_c = lanes(0);
        rst_c = 0;
        trig_c = 1;
        k = 0;
        while (qc.size() < 32 && k < 300) begin cyc(); k++; end
        trig_c = 0;
        chk("c_count", qc.size(), 32);
        for (int i = 0; i < qc.size(); i++) begin
            chk("c_data", qc[i][55:0], lanes(((i < 16) ? 4 : 25) + i));
            chk("c_last", qc[i][56], (i % 16 == 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
